occupancy_display: RTL and testbench

//  Consumes the 3-bit occupancy count from the parking-lot up/down counter and drives the user display.

---
 rtl/parking_pkg.sv | 41 ++++
 rtl/tick_prescaler.sv | 34 +++
 rtl/occupancy_display.sv | 134 +++++++++++++
 tb/tb_occupancy_display.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// -----------------------------------------------------------------------------
// parking_pkg
// Shared types and constants for the parking-lot occupancy display.
//   occ_state_t : occupancy class (EMPTY / PARTIAL / FULL)
//   SEG_DIGIT   : active-low 7-segment patterns for 0..7, bit 6 = a .. bit 0 = g
//   SEG_BLANK   : all segments off
//   classify()  : maps a raw count onto its occupancy class for a given lot size
// -----------------------------------------------------------------------------
package parking_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } occ_state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_DIGIT [0:7] = '{
    7'b0000001,  // 0
    7'b1001111,  // 1
    7'b0010010,  // 2
    7'b0000110,  // 3
    7'b1001100,  // 4
    7'b0100100,  // 5
    7'b0100000,  // 6
    7'b0001111   // 7
  };

  // Anything at or above the lot size counts as FULL, so a count that
  // overshoots CAPACITY still reads as full rather than wrapping back.
  function automatic occ_state_t classify(input logic [2:0] cnt, input int capacity);
    if (cnt == 3'd0)
      return EMPTY;
    else if ({29'd0, cnt} >= 32'(capacity))
      return FULL;
    else
      return PARTIAL;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// -----------------------------------------------------------------------------
// tick_prescaler
// Free-running modulo-DIV counter producing a one-cycle tick on its last count.
//   clk   : system clock
//   reset : asynchronous active-high reset (counter to 0)
//   clr   : synchronous restart; counter returns to 0 on the next edge
//   tick  : high while the counter sits at DIV-1, i.e. on the cycle it wraps
// -----------------------------------------------------------------------------
module tick_prescaler #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int             W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0]   LAST = W'(DIV - 1);

  logic [W-1:0] r_cnt;

  assign tick = (r_cnt == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_cnt <= '0;
    else if (clr || tick)
      r_cnt <= '0;
    else
      r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: rtl/occupancy_display.sv
// -----------------------------------------------------------------------------
// occupancy_display
// Turns the lot's 3-bit occupancy count into the user-facing display.
//   clk      in  system clock
//   reset    in  asynchronous active-high reset
//   count    in  [2:0] occupancy, already synchronous to clk
//   seg      out [6:0] active-low digit, seg[6]=a .. seg[0]=g
//   dp       out active-low decimal point, lit for FLASH_CYCLES after a change
//   led_free out 1 while the lot is not FULL
//   led_full out blinks (BLINK_DIV cycles per half-period) while FULL
//   buzzer   out beep sequence on FULL entry (build with FULL_BUZZER_EN),
//                otherwise tied low
// All outputs are registered; count reaches seg/leds one clock later.
// -----------------------------------------------------------------------------
module occupancy_display
  import parking_pkg::*;
#(
  parameter int CAPACITY     = 7,
  parameter int BLINK_DIV    = 25_000_000,
  parameter int FLASH_CYCLES = 12_500_000,
  parameter int BEEP_COUNT   = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] count,
  output logic [6:0] seg,
  output logic       dp,
  output logic       led_free,
  output logic       led_full,
  output logic       buzzer
);

  localparam int FW = $clog2(FLASH_CYCLES + 1);

  occ_state_t   r_state;
  occ_state_t   w_state_next;
  logic [6:0]   r_seg;
  logic         r_dp;
  logic         r_led_free;
  logic         r_led_full;
  logic [2:0]   r_count_q;
  logic         r_init;
  logic [FW-1:0] r_flash_cnt;
  logic [FW-1:0] w_flash_next;
  logic         r_blink_ph;
  logic         w_blink_next;
  logic         w_full_entry;
  logic         w_changed;
  logic         w_tick;

  assign w_state_next = classify(count, CAPACITY);
  assign w_full_entry = (w_state_next == FULL) && (r_state != FULL);

  // Restarting the prescaler on FULL entry guarantees the first lit
  // half-period of led_full is a complete one.
  tick_prescaler #(.DIV(BLINK_DIV)) u_blink_prescaler (
    .clk   (clk),
    .reset (reset),
    .clr   (w_full_entry),
    .tick  (w_tick)
  );

  assign w_blink_next = w_full_entry ? 1'b1 : (w_tick ? ~r_blink_ph : r_blink_ph);

  // r_init masks the first post-reset edge, where r_count_q holds a
  // meaningless reset value and a spurious "change" would be seen.
  assign w_changed    = r_init && (count != r_count_q);
  assign w_flash_next = w_changed           ? FW'(FLASH_CYCLES) :
                        (r_flash_cnt != '0) ? r_flash_cnt - 1'b1 : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= EMPTY;
      r_seg       <= SEG_BLANK;
      r_dp        <= 1'b1;
      r_led_free  <= 1'b0;
      r_led_full  <= 1'b0;
      r_count_q   <= 3'd0;
      r_init      <= 1'b0;
      r_flash_cnt <= '0;
      r_blink_ph  <= 1'b1;
    end else begin
      r_state     <= w_state_next;
      r_seg       <= SEG_DIGIT[count];
      r_led_free  <= (w_state_next != FULL);
      r_led_full  <= (w_state_next == FULL) && w_blink_next;
      r_count_q   <= count;
      r_init      <= 1'b1;
      r_flash_cnt <= w_flash_next;
      r_dp        <= (w_flash_next == '0);
      r_blink_ph  <= w_blink_next;
    end
  end

  assign seg      = r_seg;
  assign dp       = r_dp;
  assign led_free = r_led_free;
  assign led_full = r_led_full;

`ifdef FULL_BUZZER_EN
  localparam int BW = $clog2(BEEP_COUNT + 1);

  logic [BW-1:0] r_beep_left;
  logic [BW-1:0] w_beep_next;
  logic          r_buzzer;

  // One beep = an on half-period followed by an off half-period; a beep is
  // consumed when the off phase ends (tick while blink_ph is low).
  always_comb begin
    w_beep_next = r_beep_left;
    if (w_state_next != FULL)
      w_beep_next = '0;
    else if (w_full_entry)
      w_beep_next = BW'(BEEP_COUNT);
    else if (w_tick && !r_blink_ph && (r_beep_left != '0))
      w_beep_next = r_beep_left - 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_beep_left <= '0;
      r_buzzer    <= 1'b0;
    end else begin
      r_beep_left <= w_beep_next;
      r_buzzer    <= (w_state_next == FULL) && (w_beep_next != '0) && w_blink_next;
    end
  end

  assign buzzer = r_buzzer;
`else
  assign buzzer = 1'b0;
`endif

endmodule

// File: tb/tb_occupancy_display.sv
// -----------------------------------------------------------------------------
// tb_occupancy_display
// Two instances share stimulus: lot size 7 (index 0) and lot size 5 (index 1),
// both with BLINK_DIV=4, FLASH_CYCLES=6, BEEP_COUNT=3. Expected outputs come
// from a cycle-age model: time since last count change and time since FULL
// entry, from which flash, blink phase and beeps follow arithmetically.
// -----------------------------------------------------------------------------
module tb_occupancy_display;

  localparam int DIV   = 4;
  localparam int FL    = 6;
  localparam int BEEPS = 3;
  localparam int CAP0  = 7;
  localparam int CAP1  = 5;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] count = 3'd3;

  logic [6:0] seg0, seg1;
  logic       dp0, dp1, free0, free1, full0, full1, buz0, buz1;

  always #5 clk = ~clk;

  occupancy_display #(.CAPACITY(CAP0), .BLINK_DIV(DIV), .FLASH_CYCLES(FL), .BEEP_COUNT(BEEPS)) dut0 (
    .clk(clk), .reset(reset), .count(count),
    .seg(seg0), .dp(dp0), .led_free(free0), .led_full(full0), .buzzer(buz0)
  );

  occupancy_display #(.CAPACITY(CAP1), .BLINK_DIV(DIV), .FLASH_CYCLES(FL), .BEEP_COUNT(BEEPS)) dut1 (
    .clk(clk), .reset(reset), .count(count),
    .seg(seg1), .dp(dp1), .led_free(free1), .led_full(full1), .buzzer(buz1)
  );

  logic [6:0] dig_tab [0:7] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111};
  localparam logic [10:0] RST_VEC = {7'h7F, 1'b1, 1'b0, 1'b0, 1'b0};

  // Packed expectation: {seg[6:0], dp, led_free, led_full, buzzer}
  logic [10:0] exp_q0[$];
  logic [10:0] exp_q1[$];

  int checks = 0;
  int failures = 0;

  // Model state
  bit         first_edge;
  int         since_chg;
  logic [2:0] prev_cnt;
  bit         was_full [2];
  int         full_age [2];
  int         cap_of   [2] = '{CAP0, CAP1};
  int         step_no = 0;

  task automatic chk(input string name, input int k, input logic [6:0] got, input logic [6:0] expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL %s dut%0d step=%0d got=%b expected=%b", name, k, step_no, got, expv);
    end
  endtask

  task automatic cmp_vec(input string tag, input int k, input logic [10:0] got, input logic [10:0] expv);
    chk({tag, ".seg"},      k, got[10:4],        expv[10:4]);
    chk({tag, ".dp"},       k, {6'd0, got[3]},   {6'd0, expv[3]});
    chk({tag, ".led_free"}, k, {6'd0, got[2]},   {6'd0, expv[2]});
    chk({tag, ".led_full"}, k, {6'd0, got[1]},   {6'd0, expv[1]});
    chk({tag, ".buzzer"},   k, {6'd0, got[0]},   {6'd0, expv[0]});
  endtask

  function automatic logic [10:0] got_vec(input int k);
    if (k == 0) return {seg0, dp0, free0, full0, buz0};
    else        return {seg1, dp1, free1, full1, buz1};
  endfunction

  task automatic model_reset();
    first_edge = 1'b1;
    since_chg  = FL;
    prev_cnt   = 3'd0;
    for (int k = 0; k < 2; k++) begin
      was_full[k] = 1'b0;
      full_age[k] = 0;
    end
  endtask

  // Drive one count value for the coming rising edge and queue the outputs
  // both instances must show after that edge.
  task automatic step(input logic [2:0] c);
    logic [10:0] e;
    bit          full, ph, bz;
    @(negedge clk);
    count = c;
    step_no++;
    if (first_edge)            first_edge = 1'b0;
    else if (c != prev_cnt)    since_chg = 0;
    else if (since_chg < 1000) since_chg++;
    prev_cnt = c;
    for (int k = 0; k < 2; k++) begin
      full = (int'(c) >= cap_of[k]);
      if (full) full_age[k] = was_full[k] ? full_age[k] + 1 : 0;
      was_full[k] = full;
      ph = ((full_age[k] / DIV) % 2) == 0;
`ifdef FULL_BUZZER_EN
      bz = full && ph && (full_age[k] < 2 * DIV * BEEPS);
`else
      bz = 1'b0;
`endif
      e = {dig_tab[c], ~(since_chg < FL), ~full, full && ph, bz};
      if (k == 0) exp_q0.push_back(e);
      else        exp_q1.push_back(e);
    end
  endtask

  task automatic hold(input logic [2:0] c, input int n);
    for (int i = 0; i < n; i++) step(c);
  endtask

  // Monitor: outputs are sampled 1 time unit after every rising edge and
  // compared against whatever the driver queued for that edge.
  initial begin
    logic [10:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q0.size() > 0) begin
        e = exp_q0.pop_front();
        cmp_vec("out", 0, got_vec(0), e);
      end
      if (exp_q1.size() > 0) begin
        e = exp_q1.pop_front();
        cmp_vec("out", 1, got_vec(1), e);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] cur;
    model_reset();

    // Reset held with count=3: outputs blank / inactive
    repeat (3) @(posedge clk);
    #2;
    for (int k = 0; k < 2; k++) cmp_vec("reset", k, got_vec(k), RST_VEC);
    #1 reset = 1'b0;

    // First edge shows the digit without a flash
    hold(3'd3, 3);
    // Change -> 6-cycle flash
    hold(3'd0, 9);
    hold(3'd1, 3);
    // Retrigger on the third flash cycle
    hold(3'd2, 9);
    // Lot 5 goes FULL at 6, lot 7 at 7 (full beep sequence and beyond)
    hold(3'd6, 10);
    hold(3'd7, 30);
    hold(3'd6, 3);
    // Re-enter FULL, leave during the second beep
    hold(3'd7, 10);
    hold(3'd5, 4);
    hold(3'd4, 2);
    hold(3'd7, 6);

    // Asynchronous reset mid-blink, checked before any clock edge
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) cmp_vec("async_reset", k, got_vec(k), RST_VEC);
    model_reset();
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    hold(3'd7, 12);

    // Randomized section: mostly holds so flashes and blinks run out
    cur = 3'd7;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) cur = 3'($urandom_range(0, 7));
      step(cur);
    end

    @(posedge clk);
    #3;
    checks++;
    if (exp_q0.size() + exp_q1.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d expected=0", exp_q0.size() + exp_q1.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
